// File: rtl/uartb_rx.sv
// rtl/uartb_rx.sv - 8N1 receiver with normal/burst 32-bit packing; optional frame check via UARTB_RX_FERR_EN
module uartb_rx #(
    parameter int DIV_RST = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic [15:0] d,
    input  logic        wrbaud,
    input  logic        rd,
    output logic [31:0] q,
    output logic        dv,
    output logic        ovf,
    output logic        ferr,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t     state;
    logic       s1, rs, hist;
    logic [8:0] div, cnt, div_eff;
    logic       mode;
    logic [1:0] bidx;
    logic [2:0] nbit;
    logic [7:0] sh;
    logic       tick, start_edge, stop_tick, byte_ok, word_done, arm;
    logic       unused_bits;
`ifdef UARTB_RX_FERR_EN
    logic       ferr_hit, ferr_wait;
`endif

    assign unused_bits = ^d[15:10];

    // Sample timing, start detection and byte/word completion conditions
    always_comb begin
        div_eff    = (div < 9'd3) ? 9'd3 : div;
        tick       = (cnt == 9'd0);
        start_edge = hist & ~rs;
        stop_tick  = (state == STOP) && tick;
`ifdef UARTB_RX_FERR_EN
        byte_ok    = stop_tick & rs;
        ferr_hit   = stop_tick & ~rs;
        arm        = ~ferr_wait;
`else
        byte_ok    = stop_tick;
        arm        = 1'b1;
`endif
        word_done  = byte_ok & (~mode | (bidx == 2'd3));
    end

    // Two-flop synchroniser on rxd plus one history flop for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b1;
            rs   <= 1'b1;
            hist <= 1'b1;
        end else begin
            s1   <= rxd;
            rs   <= s1;
            hist <= rs;
        end
    end

    // Frame FSM: half-bit start qualification, 8 LSB-first data bits, stop bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 9'd0;
            nbit  <= 3'd0;
            sh    <= 8'd0;
            busy  <= 1'b0;
`ifdef UARTB_RX_FERR_EN
            ferr_wait <= 1'b0;
`endif
        end else begin
`ifdef UARTB_RX_FERR_EN
            // After a bad stop bit the line must be seen high before re-arming
            if (ferr_hit)
                ferr_wait <= 1'b1;
            else if (rs)
                ferr_wait <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start_edge && arm) begin
                        state <= START;
                        cnt   <= div_eff >> 1;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (rs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                            nbit  <= 3'd0;
                            cnt   <= div_eff;
                        end
                    end else begin
                        cnt <= cnt - 9'd1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        sh   <= {rs, sh[7:1]};
                        nbit <= nbit + 3'd1;
                        cnt  <= div_eff;
                        if (nbit == 3'd7)
                            state <= STOP;
                    end else begin
                        cnt <= cnt - 9'd1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= div_eff;
                    end else begin
                        cnt <= cnt - 9'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read port: byte packing, valid/overrun/frame-error flags and divider/mode register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= 32'd0;
            dv   <= 1'b0;
            ovf  <= 1'b0;
            bidx <= 2'd0;
            div  <= 9'(DIV_RST);
            mode <= 1'b0;
        end else begin
            if (byte_ok) begin
                if (mode) begin
                    q[8*bidx +: 8] <= sh;
                    bidx           <= bidx + 2'd1;
                end else begin
                    q <= {24'h0, sh};
                end
            end
            // A divider/mode write restarts burst packing at lane 0
            if (wrbaud) begin
                div  <= d[8:0];
                mode <= d[9];
                bidx <= 2'd0;
            end
            // New data beats a coincident read; overrun only when nobody read the old word
            if (word_done) begin
                dv <= 1'b1;
                if (rd)
                    ovf <= 1'b0;
                else if (dv)
                    ovf <= 1'b1;
            end else if (rd) begin
                dv  <= 1'b0;
                ovf <= 1'b0;
            end
        end
    end

`ifdef UARTB_RX_FERR_EN
    // Frame error sticks until read; a new error in the read cycle wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ferr <= 1'b0;
        else if (ferr_hit)
            ferr <= 1'b1;
        else if (rd)
            ferr <= 1'b0;
    end
`else
    assign ferr = 1'b0;
`endif

endmodule

// File: tb/tb_uartb_rx.sv
// tb/tb_uartb_rx.sv - self-checking bench for uartb_rx
module tb_uartb_rx;
    logic        clk = 1'b0;
    logic        rst, rxd, wrbaud, rd;
    logic [15:0] d;
    logic [31:0] q;
    logic        dv, ovf, ferr, busy;

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    uartb_rx #(.DIV_RST(7)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .d(d), .wrbaud(wrbaud), .rd(rd),
        .q(q), .dv(dv), .ovf(ovf), .ferr(ferr), .busy(busy)
    );

    // Reference model state: configuration, burst lane pointer and visible outputs
    int          mdiv;
    bit          mmode;
    int          mbidx;
    logic [31:0] mq;
    bit          mdv, movf, mferr;

    typedef struct {
        logic [15:0] cfg;
        int          n;
        logic [31:0] bytes;
        logic [31:0] eq;
        bit          edv;
        bit          eovf;
    } vec_t;

    vec_t vt [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int bit_time();
        return ((mdiv < 3) ? 3 : mdiv) + 1;
    endfunction

    task automatic model_reset();
        mdiv = 7; mmode = 0; mbidx = 0; mq = 32'h0; mdv = 0; movf = 0; mferr = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit stop);
        bit done;
`ifdef UARTB_RX_FERR_EN
        if (!stop) begin
            mferr = 1;
            return;
        end
`endif
        if (mmode) begin
            mq[8*mbidx +: 8] = b;
            mbidx = (mbidx + 1) % 4;
            done = (mbidx == 0);
        end else begin
            mq = {24'h0, b};
            done = 1;
        end
        if (done) begin
            if (mdv) movf = 1;
            mdv = 1;
        end
    endtask

    task automatic wr_cfg(input logic [15:0] v);
        d = v;
        wrbaud = 1'b1;
        step();
        wrbaud = 1'b0;
        d = 16'h0;
        mdiv = int'(v[8:0]);
        mmode = v[9];
        mbidx = 0;
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        step();
        rd = 1'b0;
        mdv = 0; movf = 0; mferr = 0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop);
        int bt;
        bt = bit_time();
        rxd = 1'b0;
        repeat (bt) step();
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (bt) step();
        end
        rxd = stop;
        repeat (bt) step();
        rxd = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            step();
            n++;
        end
        check("busy_idle", {31'h0, busy}, 32'h0);
        repeat (2) step();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop);
        send_frame(b, stop);
        wait_idle();
        model_byte(b, stop);
    endtask

    task automatic cmp_model(input string name);
        check({name, ".q"},    q, mq);
        check({name, ".dv"},   {31'h0, dv},   {31'h0, mdv});
        check({name, ".ovf"},  {31'h0, ovf},  {31'h0, movf});
        check({name, ".ferr"}, {31'h0, ferr}, {31'h0, mferr});
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        int          busy_at, dv_at, n;
        bit          saw_busy;
        logic [31:0] qb;

        vt[0] = '{16'h0007, 1, 32'h00000041, 32'h00000041, 1, 0};
        vt[1] = '{16'h0207, 4, 32'h44434241, 32'h44434241, 1, 0};
        vt[2] = '{16'h0007, 2, 32'h0000335A, 32'h00000033, 1, 1};
        vt[3] = '{16'h0200, 4, 32'h5AA5FF00, 32'h5AA5FF00, 1, 0};
        vt[4] = '{16'hFC02, 1, 32'h00000080, 32'h00000080, 1, 0};

        rst = 1'b1; rxd = 1'b1; wrbaud = 1'b0; rd = 1'b0; d = 16'h0;
        model_reset();
        repeat (3) step();
        cmp_model("reset");
        check("reset.busy", {31'h0, busy}, 32'h0);
        rst = 1'b0;
        repeat (4) step();

        // First reception with cycle-exact busy/dv timing at div=7
        busy_at = -1;
        dv_at = -1;
        fork
            send_frame(8'h41, 1'b1);
            begin
                for (int i = 1; i <= 200 && dv_at < 0; i++) begin
                    step();
                    if (busy && busy_at < 0) busy_at = i;
                    if (dv && dv_at < 0) dv_at = i;
                end
            end
        join
        wait_idle();
        model_byte(8'h41, 1'b1);
        check("timing.busy_rise", busy_at, 3);
        check("timing.dv_rise", dv_at, 79);
        cmp_model("first");

        // False start: 2-cycle glitch
        pulse_rd();
        rxd = 1'b0;
        repeat (2) step();
        rxd = 1'b1;
        saw_busy = 0;
        repeat (12) begin
            step();
            if (busy) saw_busy = 1;
        end
        check("glitch.saw_busy", {31'h0, saw_busy}, 32'h1);
        check("glitch.busy", {31'h0, busy}, 32'h0);
        cmp_model("glitch");

        // Table-driven vectors
        for (int v = 0; v < 5; v++) begin
            wr_cfg(vt[v].cfg);
            pulse_rd();
            for (int i = 0; i < vt[v].n; i++) begin
                send_byte(vt[v].bytes[8*i +: 8], 1'b1);
                if (vt[v].cfg[9] && i < vt[v].n - 1)
                    check($sformatf("vec%0d.burst_hold", v), {31'h0, dv}, 32'h0);
            end
            check($sformatf("vec%0d.q", v), q, vt[v].eq);
            check($sformatf("vec%0d.dv", v), {31'h0, dv}, {31'h0, vt[v].edv});
            check($sformatf("vec%0d.ovf", v), {31'h0, ovf}, {31'h0, vt[v].eovf});
            check($sformatf("vec%0d.ferr", v), {31'h0, ferr}, 32'h0);
        end

        // Overrun, then a read coinciding with the next completion
        wr_cfg(16'h0007);
        pulse_rd();
        send_byte(8'h5A, 1'b1);
        send_byte(8'h33, 1'b1);
        check("ovf.q", q, 32'h33);
        check("ovf.ovf", {31'h0, ovf}, 32'h1);
        fork
            send_frame(8'h11, 1'b1);
            begin
                repeat (78) step();
                rd = 1'b1;
                step();
                rd = 1'b0;
            end
        join
        check("prec.dv", {31'h0, dv}, 32'h1);
        check("prec.ovf", {31'h0, ovf}, 32'h0);
        check("prec.q", q, 32'h11);
        wait_idle();
        mq = 32'h11; mdv = 1; movf = 0;

        // Mode switch mid-burst discards the partial word
        pulse_rd();
        wr_cfg(16'h0207);
        send_byte(8'h41, 1'b1);
        send_byte(8'h42, 1'b1);
        cmp_model("switch.partial");
        wr_cfg(16'h0007);
        send_byte(8'h5A, 1'b1);
        check("switch.q", q, 32'h0000005A);
        check("switch.dv", {31'h0, dv}, 32'h1);

        // Bad stop bit
        pulse_rd();
        qb = q;
        send_byte(8'h41, 1'b0);
        cmp_model("badstop");
`ifdef UARTB_RX_FERR_EN
        check("ferr.set", {31'h0, ferr}, 32'h1);
        check("ferr.dv", {31'h0, dv}, 32'h0);
        check("ferr.q", q, qb);
`else
        check("noferr.q", q, 32'h41);
`endif
        pulse_rd();
        send_byte(8'h96, 1'b1);
        cmp_model("after_badstop");

        // Reset in the middle of DATA
        rxd = 1'b0;
        repeat (bit_time() * 2 + 3) step();
        check("rstmid.busy_before", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        rxd = 1'b1;
        #1;
        model_reset();
        cmp_model("rstmid");
        check("rstmid.busy", {31'h0, busy}, 32'h0);
        step();
        step();
        rst = 1'b0;
        repeat (20) step();
        send_byte(8'hC3, 1'b1);
        check("rstmid.next_q", q, 32'hC3);
        cmp_model("rstmid.next");

        // Randomized traffic against the model
        for (int it = 0; it < 60; it++) begin
            int          r;
            logic [5:0]  hi;
            logic        m;
            logic [8:0]  dvl;
            logic [7:0]  b;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                hi  = 6'($urandom);
                m   = 1'($urandom);
                dvl = 9'($urandom_range(0, 12));
                wr_cfg({hi, m, dvl});
            end else if (r < 4) begin
                pulse_rd();
            end else begin
                b = 8'($urandom);
                send_byte(b, 1'b1);
            end
            cmp_model($sformatf("rnd%0d", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
